// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the MAC operand sequencer.
// Optional abort input is enabled by defining MAC_SEQ_ABORT_EN.
package mac_seq_pkg;

    localparam int DEF_A_W     = 20;
    localparam int DEF_B_W     = 18;
    localparam int DEF_P_W     = 64;
    localparam int DEF_LEN_W   = 8;
    localparam int DEF_ACC_LAT = 2;
    localparam int SH_W        = 6;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/mac_operand_sequencer.sv
// Feeds one dot-product job into a falling-edge DSP accumulator and captures P.
// Define MAC_SEQ_ABORT_EN to add the abort_i job-cancel input.
module mac_operand_sequencer
    import mac_seq_pkg::*;
#(
    parameter int A_W     = DEF_A_W,
    parameter int B_W     = DEF_B_W,
    parameter int P_W     = DEF_P_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int ACC_LAT = DEF_ACC_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             sub_i,
    input  logic [SH_W-1:0]  shift_i,
    input  logic             round_i,
`ifdef MAC_SEQ_ABORT_EN
    input  logic             abort_i,
`endif
    input  logic             op_valid_i,
    input  logic [A_W-1:0]   op_a_i,
    input  logic [B_W-1:0]   op_b_i,
    output logic             op_ready_o,
    output logic             acc_clr_o,
    output logic [A_W-1:0]   acc_a_o,
    output logic [B_W-1:0]   acc_b_o,
    output logic             acc_load_acc_o,
    output logic             acc_subtract_o,
    output logic [SH_W-1:0]  acc_shift_right_o,
    output logic             acc_round_o,
    input  logic [P_W-1:0]   acc_p_i,
    output logic [P_W-1:0]   res_o,
    output logic             res_valid_o,
    output logic             busy_o
);

    localparam int DC_W = $clog2(ACC_LAT + 1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [DC_W-1:0]  dcnt_q, dcnt_d;
    logic             sub_q, sub_d;
    logic [SH_W-1:0]  shift_q, shift_d;
    logic             round_q, round_d;
    logic [A_W-1:0]   a_q, a_d;
    logic [B_W-1:0]   b_q, b_d;
    logic             load_q, load_d;
    logic [P_W-1:0]   res_q, res_d;
    logic             abort;

`ifdef MAC_SEQ_ABORT_EN
    assign abort = abort_i &
                   (state_q inside {CLEAR, FEED, DRAIN});
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        dcnt_d     = dcnt_q;
        sub_d      = sub_q;
        shift_d    = shift_q;
        round_d    = round_q;
        a_d        = '0;
        b_d        = '0;
        load_d     = 1'b0;
        res_d      = res_q;
        op_ready_o = 1'b0;
        acc_clr_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d   = len_i;
                    sub_d   = sub_i;
                    shift_d = shift_i;
                    round_d = round_i;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                acc_clr_o = 1'b1;
                cnt_d     = '0;
                dcnt_d    = '0;
                state_d   = (len_q == '0) ? DRAIN : FEED;
            end
            FEED: begin
                dcnt_d     = '0;
                op_ready_o = (cnt_q < len_q);
                if (op_ready_o && op_valid_i) begin
                    a_d    = op_a_i;
                    b_d    = op_b_i;
                    load_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_d == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // acc_p_i trails the last load beat by ACC_LAT edges
                if (dcnt_q == DC_W'(ACC_LAT)) begin
                    res_d   = acc_p_i;
                    state_d = DONE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d    = IDLE;
            acc_clr_o  = 1'b1;
            op_ready_o = 1'b0;
            a_d        = '0;
            b_d        = '0;
            load_d     = 1'b0;
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            dcnt_q  <= '0;
            sub_q   <= 1'b0;
            shift_q <= '0;
            round_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            load_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            dcnt_q  <= dcnt_d;
            sub_q   <= sub_d;
            shift_q <= shift_d;
            round_q <= round_d;
            a_q     <= a_d;
            b_q     <= b_d;
            load_q  <= load_d;
            res_q   <= res_d;
        end
    end

    assign acc_a_o           = a_q;
    assign acc_b_o           = b_q;
    assign acc_load_acc_o    = load_q;
    assign acc_subtract_o    = sub_q;
    assign acc_shift_right_o = shift_q;
    assign acc_round_o       = round_q;
    assign res_o             = res_q;
    assign res_valid_o       = (state_q == DONE);
    assign busy_o            = (state_q != IDLE);

endmodule
